// File: rtl/node_pkg.sv
// Shared types and constants for the neuron-node feeder.
package node_pkg;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    // One IEEE-754 single per lane
    localparam int LANE_W = 32;

endpackage

// File: rtl/node_feeder.sv
// Deserialises activation words into NUM_IN node lanes, waits for the node to settle,
// and returns its thresholded output. `define FLOAT_RESULT_EN to return 1.0/0.0 floats.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_LOAD   | accepting words into lane[idx]
// S_SETTLE | lanes frozen, cnt counts down until node output is fresh
// S_RESULT | res_data offered downstream until res_ready
module node_feeder
    import node_pkg::*;
#(
    parameter int NUM_IN = 10,
    parameter int SETTLE = 2,
    parameter int DW     = LANE_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_data,
    output logic [NUM_IN*DW-1:0] lanes,
    input  logic [DW-1:0]        node_out,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [DW-1:0]        res_data,
    output logic                 busy
);

    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int CNT_W = $clog2(SETTLE + 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    logic [DW-1:0]      lane_q [NUM_IN];

    assign in_ready = (state == S_LOAD);
    assign busy     = (state != S_LOAD);

    for (genvar g = 0; g < NUM_IN; g++) begin : g_lanes
        assign lanes[g*DW +: DW] = lane_q[g];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_LOAD;
            idx       <= '0;
            cnt       <= '0;
            res_valid <= 1'b0;
            res_data  <= FP_ZERO;
            for (int i = 0; i < NUM_IN; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        lane_q[idx] <= in_data;
                        if (idx == IDX_W'(NUM_IN - 1)) begin
                            idx   <= '0;
                            cnt   <= CNT_W'(SETTLE);
                            state <= S_SETTLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_SETTLE: begin
                    cnt <= cnt - 1'b1;
                    // Terminal count: the node has registered the sum of this frame
                    if (cnt == CNT_W'(1)) begin
`ifdef FLOAT_RESULT_EN
                        res_data <= (node_out != '0) ? FP_ONE : FP_ZERO;
`else
                        res_data <= node_out;
`endif
                        res_valid <= 1'b1;
                        state     <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_LOAD;
                    end
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

endmodule
